fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch from the byte-wide instruction memory: owns the PC, issues four byte reads per instruction, assembles a little-endian 32-bit word and hands it to decode.
//  Sits between the IMem byte port and InstructionDecode. Applies PCSrc/BranchAddress redirects and stops fetching after the HALT opcode.
// PARAMETERS
//  PC_W      64     PC / byte-address width
//  RESET_PC  0      PC value loaded on reset
// PORTS
//  clk           in   1     clock, rising edge
//  reset         in   1     synchronous, active-high
//  mem_req       out  1     byte read request; held until mem_valid
//  mem_addr      out  PC_W  byte address (PC + byte_idx)
//  mem_rdata     in   8     read byte
//  mem_valid     in   1     byte valid; legal only while mem_req=1
//  inst_valid    out  1     assembled instruction available
//  inst_ready    in   1     decode accepts instruction
//  inst          out  32    instruction, {b3,b2,b1,b0}
//  inst_pc       out  PC_W  address of inst
//  pc_src        in   1     redirect strobe (PCSrc)
//  branch_addr   in   PC_W  redirect target (BranchAddress)
//  halted        out  1     HALT delivered; fetch stopped
//  fault         out  1     misaligned-target fault (macro only, else tied 0)
// BEHAVIOUR
//  - Reset: clk and reset are one clock domain; reset is synchronous and active-high. Reset returns every register on the next edge, including when asserted mid-fetch.
//    Values after reset: state=FETCH, PC=RESET_PC, byte_idx=0, mem_req=0, inst_valid=0, inst=0, inst_pc=0, halted=0, fault=0.
//    The first mem_req is raised in the cycle after reset deasserts.
//  - FSM: FETCH -> DELIVER -> FETCH | HALTED. HALTED is terminal until reset.
//  - FETCH: mem_req=1 and mem_addr=PC+byte_idx, both stable until mem_valid.
//    On each mem_valid edge, byte_idx selects the capture slot. byte_idx is 2 bits and increments by 1.
//    When byte 3 is captured, go to DELIVER. inst_pc=PC is latched at the same edge.
//    With a zero-wait memory (mem_valid=1 in the request cycle) this takes 4 cycles per instruction.
//  - DELIVER: mem_req=0. inst_valid=1, and inst and inst_pc stay stable until inst_ready.
//    On handshake: PC<=PC+4, modulo 2^PC_W (wraps to 0, no flag). If inst[31:21]==HALT_OP, go to HALTED, else go to FETCH.
//  - Redirect (pc_src=1): accepted in FETCH and DELIVER, ignored in HALTED. Highest priority.
//    Next edge: PC<=branch_addr, byte_idx<=0, inst_valid<=0, state<=FETCH.
//    A mem_valid byte in the same cycle is discarded. A held, un-accepted instruction is dropped.
//  - Redirect in the same cycle as a handshake: the instruction counts as consumed, and the redirect target overrides PC+4.
//    If that instruction was HALT, halt wins and the redirect is ignored.
//  - HALTED: halted=1, mem_req=0, inst_valid=0. All inputs except reset are ignored.
//  - No combinational path from inputs to outputs. Max one outstanding byte request.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined:
//    A redirect with branch_addr[1:0]!=0 is not taken. Next edge: fault<=1, halted<=1, state<=HALTED, PC<=branch_addr (kept for debug).
//  Not defined:
//    No check. Misaligned targets are fetched as-is from byte addresses. fault is tied to 0.
// STRUCTURE
//  Package fetch_pkg holds:
//    state enum {FETCH, DELIVER, HALTED}
//    HALT_OP = 11'h7FF
//    INST_BYTES = 4
//    PC_INC = 4
//  Sub-module byte_assembler: 4x8 capture register plus byte_idx counter, with clear on redirect/reset.
// TESTING
//  1. Reset then zero-wait memory holding 0x8B020020 at 0..3 -> mem_addr 0,1,2,3; inst=0x8B020020, inst_pc=0, inst_valid on cycle 5.
//  2. inst_ready held low 3 cycles -> inst and inst_pc stable and mem_req=0 throughout. After ready: next mem_addr=4.
//  3. pc_src=1, branch_addr=0x40 while byte_idx=2 -> captured bytes discarded, next mem_addr=0x40, inst_pc=0x40.
//  4. Word 0xFFE00000 at 0x8 -> delivered once, then halted=1 and mem_req stays 0. A later pc_src is ignored.
//  5. Memory with 2 wait cycles per byte -> 12-cycle fetch; mem_addr stable during waits.
//  6. With FETCH_ALIGN_CHECK_EN: pc_src with branch_addr=0x42 -> fault=1, halted=1, no mem_req.
//     Without the macro: fetch proceeds from 0x42.
//  7. reset pulsed mid-DELIVER -> all outputs return to reset values next edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DELIVER = 2'd1,
        HALTED  = 2'd2
    } state_t;

    localparam logic [10:0] HALT_OP    = 11'h7FF;
    localparam int          INST_BYTES = 4;
    localparam int          PC_INC     = 4;

    function automatic logic is_halt(input logic [31:0] word);
        return word[31:21] == HALT_OP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : byte_assembler
// Purpose  : Captures four bytes into a little-endian word, tracks byte index.
// Revision : 1.0 - initial release
// ============================================================================
module byte_assembler
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        capture,
    input  logic [7:0]  rdata,
    output logic [1:0]  byte_idx,
    output logic        last,
    output logic [31:0] word
);

    logic [7:0] r_bytes [INST_BYTES];
    logic [1:0] r_idx;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < INST_BYTES; i++) begin
                r_bytes[i] <= 8'h00;
            end
            r_idx <= 2'd0;
        end else if (capture) begin
            r_bytes[r_idx] <= rdata;
            r_idx          <= r_idx + 2'd1;
        end
    end

    assign byte_idx = r_idx;
    assign last     = (r_idx == 2'd3);
    assign word     = {r_bytes[3], r_bytes[2], r_bytes[1], r_bytes[0]};

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Owns the PC, fetches 4 bytes per instruction, hands words to
//            decode. Optional macro FETCH_ALIGN_CHECK_EN faults on misaligned
//            redirect targets.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic [7:0]      mem_rdata,
    input  logic            mem_valid,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [PC_W-1:0] inst_pc,
    input  logic            pc_src,
    input  logic [PC_W-1:0] branch_addr,
    output logic            halted,
    output logic            fault
);

    localparam logic [PC_W-1:0] c_pc_inc = PC_W'(PC_INC);

    state_t          r_state;
    state_t          w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_inst_pc;
    logic            r_mem_req;

    logic [1:0]      w_byte_idx;
    logic            w_last_slot;
    logic [31:0]     w_word;
    logic            w_handshake;
    logic            w_halt_hs;
    logic            w_redirect;
    logic            w_misaligned;
    logic            w_capture;
    logic            w_last;

    assign w_handshake = (r_state == DELIVER) && inst_ready;
    assign w_halt_hs   = w_handshake && is_halt(w_word);
    // A delivered HALT takes precedence over a coincident redirect.
    assign w_redirect  = pc_src && (r_state != HALTED) && !w_halt_hs;
    assign w_capture   = (r_state == FETCH) && r_mem_req && mem_valid && !w_redirect;
    assign w_last      = w_capture && w_last_slot;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;
    assign w_misaligned = w_redirect && (branch_addr[1:0] != 2'b00);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_misaligned) begin
            r_fault <= 1'b1;
        end
    end
    assign fault = r_fault;
`else
    assign w_misaligned = 1'b0;
    assign fault        = 1'b0;
`endif

    byte_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_redirect),
        .capture  (w_capture),
        .rdata    (mem_rdata),
        .byte_idx (w_byte_idx),
        .last     (w_last_slot),
        .word     (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH: begin
                if (w_misaligned)    w_next_state = HALTED;
                else if (w_redirect) w_next_state = FETCH;
                else if (w_last)     w_next_state = DELIVER;
            end
            DELIVER: begin
                if (w_halt_hs)         w_next_state = HALTED;
                else if (w_misaligned) w_next_state = HALTED;
                else if (w_redirect)   w_next_state = FETCH;
                else if (w_handshake)  w_next_state = FETCH;
            end
            HALTED:  w_next_state = HALTED;
            default: w_next_state = FETCH;
        endcase
    end

    always_comb begin
        mem_req    = r_mem_req;
        inst_valid = (r_state == DELIVER);
        halted     = (r_state == HALTED);
    end

    // Request is registered so it first rises the cycle after reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_inst_pc <= '0;
            r_mem_req <= 1'b0;
        end else begin
            r_mem_req <= (w_next_state == FETCH);
            if (w_halt_hs) begin
                r_pc <= r_pc + c_pc_inc;
            end else if (w_redirect) begin
                r_pc <= branch_addr;
            end else if (w_handshake) begin
                r_pc <= r_pc + c_pc_inc;
            end
            if (w_last) begin
                r_inst_pc <= r_pc;
            end
        end
    end

    assign mem_addr = r_pc + PC_W'(w_byte_idx);
    assign inst     = w_word;
    assign inst_pc  = r_inst_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Randomized self-checking bench with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int PC_W = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic [7:0]      mem_rdata;
    logic            mem_valid;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [PC_W-1:0] inst_pc;
    logic            pc_src;
    logic [PC_W-1:0] branch_addr;
    logic            halted;
    logic            fault;

    always #5 clk = ~clk;

    fetch_sequencer #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .pc_src      (pc_src),
        .branch_addr (branch_addr),
        .halted      (halted),
        .fault       (fault)
    );

    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;

    // Model: PC of the instruction being fetched/held, bytes received so far.
    logic [63:0] m_pc;
    int          m_n;
    bit          m_have, m_halted, m_armed, m_fault;
    int          cyc;
    int          wcnt, wmax, wait_cfg;
    bit          rand_wait;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return {mem[8'(a + 3)], mem[8'(a + 2)], mem[8'(a + 1)], mem[8'(a)]};
    endfunction

    task automatic check_outputs();
        bit          exp_req;
        logic [31:0] w;
        exp_req = m_armed && !m_have && !m_halted;
        check("mem_req", mem_req, exp_req);
        if (exp_req) check("mem_addr", mem_addr, m_pc + 64'(m_n));
        check("inst_valid", inst_valid, m_have);
        if (m_have) begin
            w = word_at(m_pc);
            check("inst", inst, w);
            check("inst_pc", inst_pc, m_pc);
        end
        check("halted", halted, m_halted);
        check("fault", fault, m_fault);
    endtask

    task automatic step(input bit rdy, input bit src, input logic [63:0] tgt);
        bit          exp_req, valid, hs, hlt;
        logic [31:0] w;
        exp_req = m_armed && !m_have && !m_halted;
        valid   = exp_req && (wcnt >= wmax);
        mem_valid   = valid;
        mem_rdata   = valid ? mem[8'(m_pc + 64'(m_n))] : 8'($urandom);
        inst_ready  = rdy;
        pc_src      = src;
        branch_addr = tgt;
        if (valid) begin
            wcnt = 0;
            wmax = rand_wait ? int'($urandom_range(0, 2)) : wait_cfg;
        end else if (exp_req) begin
            wcnt++;
        end
        if (!m_halted) begin
            w   = word_at(m_pc);
            hs  = m_have && rdy;
            hlt = hs && (w[31:21] == 11'h7FF);
            if (hlt) begin
                m_halted = 1'b1;
                m_have   = 1'b0;
                m_pc     = m_pc + 64'd4;
            end else if (src) begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (tgt[1:0] != 2'b00) begin
                    m_halted = 1'b1;
                    m_fault  = 1'b1;
                end
`endif
                m_pc   = tgt;
                m_n    = 0;
                m_have = 1'b0;
            end else if (hs) begin
                m_pc   = m_pc + 64'd4;
                m_have = 1'b0;
            end else if (valid) begin
                m_n++;
                if (m_n == 4) begin
                    m_n    = 0;
                    m_have = 1'b1;
                end
            end
        end
        m_armed = 1'b1;
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        mem_valid   = 1'b0;
        pc_src      = 1'b0;
        inst_ready  = 1'b0;
        branch_addr = '0;
        @(negedge clk);
        reset    = 1'b0;
        m_pc     = 64'd0;
        m_n      = 0;
        m_have   = 1'b0;
        m_halted = 1'b0;
        m_armed  = 1'b0;
        m_fault  = 1'b0;
        cyc      = 0;
        wcnt     = 0;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 64'h0);
        check("rst_halted", halted, 1'b0);
        check("rst_fault", fault, 1'b0);
    endtask

    task automatic wait_inst(input string tag, output int n);
        n = 0;
        while (!inst_valid && n < 100) begin
            step(1'b0, 1'b0, 64'd0);
            n++;
        end
        check(tag, inst_valid, 1'b1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        mem_valid = 1'b0; mem_rdata = 8'h00; inst_ready = 1'b0;
        pc_src = 1'b0; branch_addr = '0;
        rand_wait = 1'b0; wait_cfg = 0; wmax = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom) & 8'h7F;
        {mem[3], mem[2], mem[1], mem[0]}   = 32'h8B020020;
        {mem[11], mem[10], mem[9], mem[8]} = 32'hFFE00000;

        // Zero-wait fetch from reset
        do_reset();
        wait_inst("t1_valid", n);
        check("t1_latency", 64'(cyc), 64'd5);
        check("t1_inst", inst, 32'h8B020020);

        // Decode stalls, then accepts
        repeat (3) step(1'b0, 1'b0, 64'd0);
        check("t2_hold_inst", inst, 32'h8B020020);
        step(1'b1, 1'b0, 64'd0);
        check("t2_next_addr", mem_addr, 64'd4);

        // Redirect with two bytes captured
        n = 0;
        while (m_n != 2 && n < 20) begin step(1'b0, 1'b0, 64'd0); n++; end
        step(1'b0, 1'b1, 64'h40);
        check("t3_redirect_addr", mem_addr, 64'h40);
        wait_inst("t3_valid", n);
        check("t3_inst_pc", inst_pc, 64'h40);

        // Handshake with redirect to the HALT word, then halt
        step(1'b1, 1'b1, 64'h8);
        wait_inst("t4_valid", n);
        check("t4_inst", inst, 32'hFFE00000);
        step(1'b1, 1'b0, 64'd0);
        check("t4_halted", halted, 1'b1);
        repeat (4) step(1'b1, 1'b1, 64'h40);
        check("t4_no_req", mem_req, 1'b0);

        // Two wait cycles per byte
        do_reset();
        wait_cfg = 2; wmax = 2;
        wait_inst("t5_first", n);
        step(1'b1, 1'b0, 64'd0);
        wait_inst("t5_valid", n);
        check("t5_fetch_cycles", 64'(n), 64'd12);
        wait_cfg = 0; wmax = 0;

        // Misaligned redirect target
        step(1'b0, 1'b1, 64'h42);
`ifdef FETCH_ALIGN_CHECK_EN
        check("t6_fault", fault, 1'b1);
        check("t6_halted", halted, 1'b1);
        repeat (3) step(1'b0, 1'b0, 64'd0);
        check("t6_no_req", mem_req, 1'b0);
`else
        check("t6_addr", mem_addr, 64'h42);
        wait_inst("t6_valid", n);
        check("t6_inst_pc", inst_pc, 64'h42);
`endif

        // Reset while holding an instruction
        do_reset();
        wait_inst("t7_valid", n);
        do_reset();
        step(1'b0, 1'b0, 64'd0);
        check("t7_restart_addr", mem_addr, 64'd0);

        // Randomized traffic; the HALT word stays reachable at 0x8
        rand_wait = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (m_halted) do_reset();
            step($urandom_range(0, 9) < 6, $urandom_range(0, 99) < 4,
                 64'($urandom_range(0, 63)) * 64'd4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
